lc3_mem_bridge: RTL
===================

// Module: lc3_mem_bridge
// PURPOSE
//  Memory/IO bridge between LC-3 datapath (MAR, MDR, MDR_In) and an async SRAM port.
//  Decodes memory-mapped I/O at IO_ADDR: reads return synchronized switches, writes load hex-display reg.
//  Generates SRAM strobes with a fixed wait-state count; completion handshake (MEM_RDY) to control FSM.
// PARAMETERS
//  WAIT_STATES  2        extra SRAM access cycles beyond the first (0..15)
//  IO_ADDR      16'hFFFF memory-mapped I/O address (switches on read, hex reg on write)
// PORTS
//  Clk          in   1   system clock; all state on rising edge
//  Reset        in   1   synchronous, active-high
//  MEM_REQ      in   1   access request from control FSM; held until MEM_RDY
//  MEM_WE       in   1   1=write, 0=read; sampled with MEM_REQ
//  MAR          in   16  access address
//  MDR          in   16  write data
//  SW           in   10  asynchronous board switches
//  MDR_In       out  16  read data to datapath MDR
//  MEM_RDY      out  1   one-cycle completion pulse
//  HEX_Data     out  16  hex-display register
//  SRAM_ADDR    out  16  SRAM address
//  SRAM_CE_N    out  1   chip enable, active-low
//  SRAM_OE_N    out  1   output enable, active-low
//  SRAM_WE_N    out  1   write enable, active-low
//  SRAM_DQ_OUT  out  16  SRAM write data
//  SRAM_DQ_OE   out  1   1=drive SRAM_DQ_OUT onto bus (top-level tristate)
//  SRAM_DQ_IN   in   16  SRAM read data
// BEHAVIOUR
//  Reset: state=IDLE; MEM_RDY=0, MDR_In=0, HEX_Data=0, SRAM_ADDR=0, all _N strobes=1, SRAM_DQ_OE=0,
//   SRAM_DQ_OUT=0, wait counter=0, switch sync flops=0. Reset mid-access aborts; no strobe past that edge.
//  States: IDLE, ACCESS, DONE.
//  IDLE: MEM_REQ=1 -> latch MAR/MDR/MEM_WE; is_io = (MAR==IO_ADDR).
//   is_io -> DONE (no SRAM strobes); else -> ACCESS, counter=WAIT_STATES.
//  ACCESS: SRAM_ADDR=latched addr, CE_N=0; read: OE_N=0; write: WE_N=0, DQ_OE=1, DQ_OUT=latched data.
//   counter!=0 -> decrement, stay; counter==0 -> capture SRAM_DQ_IN (read), go DONE.
//   ACCESS lasts exactly WAIT_STATES+1 cycles.
//  DONE: MEM_RDY=1 for exactly one cycle; strobes inactive, DQ_OE=0; -> IDLE unconditionally.
//  Latency (MEM_REQ sampled at edge 0): SRAM MEM_RDY high after edge WAIT_STATES+2; IO after edge 1.
//  Read data: MDR_In updated at DONE entry; holds until next read completes (writes leave it unchanged).
//  IO read: MDR_In = {6'b0, SW_sync}; SW through 2-flop synchronizer (2-cycle input latency).
//  IO write: HEX_Data <= latched MDR at DONE entry; SRAM untouched.
//  MEM_REQ only sampled in IDLE; MEM_REQ still high in DONE is not a new request (min 1 IDLE cycle between).
//  MEM_REQ dropped mid-ACCESS: access still completes and MEM_RDY still pulses (no abort).
//  MAR/MDR changes after acceptance are ignored (latched copies used).
//  Counter width 4 bits; no wrap: load only in IDLE, decrement only when nonzero.
//  All outputs registered.
// STRUCTURE
//  Package lc3_mem_pkg: typedef enum logic[1:0] {IDLE, ACCESS, DONE} mem_state_t; localparam IO_ADDR_DEF=16'hFFFF.
//  Sub-module sw_sync: parameterized-width 2-flop synchronizer for SW (sync Reset to 0).
//  Remainder (FSM, counter, latches, strobe regs) in lc3_mem_bridge.
// TESTING
//  1 SRAM write: WAIT_STATES=2, MAR=16'h0010, MDR=16'hBEEF, WE=1 -> WE_N=0 and DQ_OE=1 for 3 cycles,
//    SRAM_ADDR=16'h0010, MEM_RDY pulse after edge 4; MDR_In unchanged.
//  2 SRAM read: model returns 16'h1234 at 16'h0010 -> OE_N=0 3 cycles, MDR_In=16'h1234 with MEM_RDY.
//  3 IO: SW=10'h2A5 held 3 cycles, read MAR=16'hFFFF -> MDR_In=16'h02A5, MEM_RDY after edge 1, CE_N stays 1;
//    write MDR=16'h00C3 to 16'hFFFF -> HEX_Data=16'h00C3, no SRAM strobe.
//  4 Handshake: MEM_REQ held high through DONE -> exactly one MEM_RDY per accepted request, IDLE cycle between;
//    MEM_REQ dropped mid-ACCESS -> MEM_RDY still pulses; MAR changed mid-ACCESS -> SRAM_ADDR unchanged.
//  5 Reset mid-ACCESS (cycle 2 of write) -> next edge: IDLE, WE_N=1, DQ_OE=0, HEX_Data=0, no MEM_RDY.
//  6 WAIT_STATES=0 rebuild: read -> ACCESS 1 cycle, MEM_RDY after edge 2.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory/IO bridge.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;

    // Request captured when the bridge accepts MEM_REQ; later MAR/MDR changes do not matter.
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        we;
        logic        is_io;
    } mem_req_t;

endpackage

// File: rtl/sw_sync.sv
// Two-flop synchronizer that brings the asynchronous board switches into the Clk domain.
module sw_sync #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability stage followed by the stable output stage.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/lc3_mem_bridge.sv
// LC-3 memory/IO bridge: latches a datapath request, decodes the memory-mapped
// switch/hex register, and runs the async SRAM strobes for a fixed number of wait
// states. Every output is a flop driven from the current FSM state, so strobes trail
// the state by one cycle and the read data is captured while OE_N is still asserted.
module lc3_mem_bridge
    import lc3_mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [9:0]  SW,
    output logic [15:0] MDR_In,
    output logic        MEM_RDY,
    output logic [15:0] HEX_Data,
    output logic [15:0] SRAM_ADDR,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_DQ_IN
);

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    mem_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    mem_req_t    req_q, req_d;
    logic [9:0]  sw_sync_w;

    logic [15:0] mdr_in_q, mdr_in_d;
    logic        mem_rdy_q, mem_rdy_d;
    logic [15:0] hex_q, hex_d;
    logic [15:0] sram_addr_q, sram_addr_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic        dq_oe_q, dq_oe_d;

    sw_sync #(
        .WIDTH (10)
    ) u_sw_sync (
        .Clk     (Clk),
        .Reset   (Reset),
        .async_i (SW),
        .sync_o  (sw_sync_w)
    );

    // Next-state logic: accept requests only in IDLE, count wait states in ACCESS.
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (MEM_REQ) begin
                    req_d.addr  = MAR;
                    req_d.data  = MDR;
                    req_d.we    = MEM_WE;
                    req_d.is_io = (MAR == IO_ADDR);
                    if (MAR == IO_ADDR) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = WS_INIT;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register inputs decoded from the current state; data registers hold by default.
    always_comb begin
        mdr_in_d    = mdr_in_q;
        mem_rdy_d   = 1'b0;
        hex_d       = hex_q;
        sram_addr_d = sram_addr_q;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        case (state_q)
            ACCESS: begin
                sram_addr_d = req_q.addr;
                ce_n_d      = 1'b0;
                if (req_q.we) begin
                    we_n_d   = 1'b0;
                    dq_oe_d  = 1'b1;
                    dq_out_d = req_q.data;
                end else begin
                    oe_n_d = 1'b0;
                end
            end
            DONE: begin
                mem_rdy_d = 1'b1;
                if (req_q.is_io) begin
                    if (req_q.we) begin
                        hex_d = req_q.data;
                    end else begin
                        mdr_in_d = {6'b0, sw_sync_w};
                    end
                end else if (!req_q.we) begin
                    // OE_N is still low during this cycle, so the SRAM is driving valid data.
                    mdr_in_d = SRAM_DQ_IN;
                end
            end
            default: begin
            end
        endcase
    end

    // State, counter, latched request and all output flops; reset aborts any access.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_q       <= '0;
            mdr_in_q    <= 16'h0000;
            mem_rdy_q   <= 1'b0;
            hex_q       <= 16'h0000;
            sram_addr_q <= 16'h0000;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_out_q    <= 16'h0000;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            mdr_in_q    <= mdr_in_d;
            mem_rdy_q   <= mem_rdy_d;
            hex_q       <= hex_d;
            sram_addr_q <= sram_addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign MDR_In      = mdr_in_q;
    assign MEM_RDY     = mem_rdy_q;
    assign HEX_Data    = hex_q;
    assign SRAM_ADDR   = sram_addr_q;
    assign SRAM_CE_N   = ce_n_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_DQ_OUT = dq_out_q;
    assign SRAM_DQ_OE  = dq_oe_q;

endmodule
